// File: rtl/sar_search_4bit.sv
// Successive-approximation controller: drives a trial operand onto a registered comparator
// and resolves one bit per step, MSB first, reporting the recovered value with a done pulse.
module sar_search_4bit #(
  parameter int WIDTH       = 4,
  parameter int CMP_LATENCY = 1   // must be >= 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_e,
  input  logic             cmp_g,
  input  logic             cmp_l,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (CMP_LATENCY > 1) ? $clog2(CMP_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    bit_idx;
  logic [CW-1:0]    wait_cnt;
  logic [WIDTH-1:0] trial_nxt;
  logic             accept, verdict_ok, keep, wait_last;

  // The done cycle itself never accepts a start; the following cycle can.
  assign accept     = (state == IDLE) && start && !done;
  assign verdict_ok = $onehot({cmp_e, cmp_g, cmp_l});
  assign keep       = verdict_ok && (cmp_g || cmp_e);
  assign wait_last  = (wait_cnt == CW'(CMP_LATENCY - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (wait_last) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (bit_idx == '0) ? IDLE : WAIT;
      default: state_nxt = IDLE;
    endcase
  end

  // Resolve the current bit and arm the next lower one; invalid verdicts clear like L.
  always_comb begin
    trial_nxt          = trial;
    trial_nxt[bit_idx] = keep;
    if (bit_idx != '0) trial_nxt[bit_idx - 1'b1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trial    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      err      <= 1'b0;
      bit_idx  <= '0;
      wait_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            trial    <= {1'b1, {(WIDTH-1){1'b0}}};
            busy     <= 1'b1;
            err      <= 1'b0;
            bit_idx  <= IW'(WIDTH - 1);
            wait_cnt <= '0;
          end
        end
        WAIT: wait_cnt <= wait_cnt + 1'b1;
        SAMPLE: begin
          trial    <= trial_nxt;
          wait_cnt <= '0;
          if (!verdict_ok) err <= 1'b1;
          if (bit_idx == '0) begin
            result <= trial_nxt;
            done   <= 1'b1;
            busy   <= 1'b0;
          end else begin
            bit_idx <= bit_idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
